// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation commit checker: reference log item, key type codes, checker FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package cosim_pkg;

   localparam int KEY_W = 64;
   localparam int VAL_W = 128;

   // Low nibble of a register key encodes the register class.
   localparam logic [3:0] REG_KEY_TYPE_CSR = 4'b0100;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } commit_log_reg_item_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } checker_state_e;

endpackage

// File: rtl/cosim_multi_pop_fifo.sv
// Circular FIFO with one push and 0..PopW pops per cycle, exposing the PopW head entries; 0-cycle read, 1-cycle write.
// No internal backpressure: caller pushes only when count_o < Depth and pops no more than count_o.
module cosim_multi_pop_fifo
   import cosim_pkg::*;
#(
   parameter int  Depth = 16,
   parameter int  PopW  = 2,
   parameter type item_t = commit_log_reg_item_t
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          push_i,
   input  item_t                         push_item_i,
   input  logic [$clog2(PopW+1)-1:0]     pop_cnt_i,
   output item_t                         head_o [PopW],
   output logic [$clog2(Depth):0]        count_o
);

   localparam int AW = $clog2(Depth);

   item_t          r_mem [Depth];
   logic [AW-1:0]  r_head;
   logic [AW-1:0]  r_tail;
   logic [AW:0]    r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (push_i) begin
            r_tail <= r_tail + AW'(1);
         end
         r_head  <= r_head + AW'(pop_cnt_i);
         r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_cnt_i);
      end
   end

   // Storage needs no reset: entries are only observed once count covers them.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         r_mem[r_tail] <= push_item_i;
      end
   end

   always_comb begin
      for (int i = 0; i < PopW; i++) begin
         head_o[i] = r_mem[r_head + AW'(i)];
      end
   end

   assign count_o = r_count;

endmodule

// File: rtl/cosim_commit_checker.sv
// In-order scoreboard of DUT register commits (up to NumChannels/cycle) against a reference FIFO; results 1 cycle later.
// Reference side is valid/ready (ready = not full, pops ignored); DUT side has no backpressure and is flagged on underflow.
module cosim_commit_checker
   import cosim_pkg::*;
#(
   parameter int NumChannels = 2,
   parameter int RefDepth    = 16,
   parameter int KeyW        = KEY_W,
   parameter int ValW        = VAL_W,
   parameter int CntW        = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_skip_csr_i,
   input  logic                          cfg_halt_on_mismatch_i,
   input  logic                          ref_valid_i,
   output logic                          ref_ready_o,
   input  logic [KeyW-1:0]               ref_key_i,
   input  logic [ValW-1:0]               ref_value_i,
   input  logic [NumChannels-1:0]        dut_valid_i,
   input  logic [NumChannels*KeyW-1:0]   dut_key_i,
   input  logic [NumChannels*ValW-1:0]   dut_value_i,
   output logic                          match_o,
   output logic                          mismatch_o,
   output logic [KeyW-1:0]               mm_key_o,
   output logic [ValW-1:0]               mm_exp_o,
   output logic [ValW-1:0]               mm_got_o,
   output logic [CntW-1:0]               match_count_o,
   output logic [CntW-1:0]               mismatch_count_o,
   output logic [CntW-1:0]               skip_count_o,
   output logic [$clog2(RefDepth):0]     occupancy_o,
   output logic                          underflow_o,
   output logic                          protocol_err_o,
   output logic                          halted_o
);

   localparam int OccW = $clog2(RefDepth) + 1;
   localparam int KW   = $clog2(NumChannels + 1);

   function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [KW-1:0] b);
      logic [CntW:0] s;
      s = {1'b0, a} + {{(CntW+1-KW){1'b0}}, b};
      return s[CntW] ? {CntW{1'b1}} : s[CntW-1:0];
   endfunction

   checker_state_e        r_state;
   checker_state_e        w_state_next;

   commit_log_reg_item_t  w_push_item;
   commit_log_reg_item_t  w_head [NumChannels];
   logic [OccW-1:0]       w_occ;
   logic [KW-1:0]         w_pop_cnt;

   logic                  w_push;
   logic                  w_skip;
   logic                  w_store;
   logic [KW-1:0]         w_k;
   logic                  w_any;
   logic                  w_contig;
   logic                  w_proto;
   logic                  w_under;
   logic                  w_cmp;

   logic [KW-1:0]         w_nmatch;
   logic [KW-1:0]         w_nmis;
   logic                  w_found;
   logic [KeyW-1:0]       w_fkey;
   logic [ValW-1:0]       w_fexp;
   logic [ValW-1:0]       w_fgot;

   logic                  r_match;
   logic                  r_mismatch;
   logic                  r_mm_vld;
   logic [KeyW-1:0]       r_mm_key;
   logic [ValW-1:0]       r_mm_exp;
   logic [ValW-1:0]       r_mm_got;
   logic [CntW-1:0]       r_match_cnt;
   logic [CntW-1:0]       r_mis_cnt;
   logic [CntW-1:0]       r_skip_cnt;
   logic                  r_underflow;
   logic                  r_proto;

   // Readiness looks only at start-of-cycle occupancy, never at a concurrent pop.
   assign ref_ready_o = ~rst_i & (w_occ < OccW'(RefDepth));
   assign w_push      = ref_valid_i & ref_ready_o;
   assign w_skip      = w_push & cfg_skip_csr_i & (ref_key_i[3:0] == REG_KEY_TYPE_CSR);
   assign w_store     = w_push & ~w_skip;

   always_comb begin
      w_push_item       = '0;
      w_push_item.key   = KEY_W'(ref_key_i);
      w_push_item.value = VAL_W'(ref_value_i);
   end

   always_comb begin
      w_k = '0;
      for (int i = 0; i < NumChannels; i++) begin
         w_k = w_k + KW'(dut_valid_i[i]);
      end
   end

   // A thermometer code 0..01..1 has no bit set that survives v & (v+1).
   assign w_any    = |dut_valid_i;
   assign w_contig = ((dut_valid_i & (dut_valid_i + NumChannels'(1))) == '0);
   assign w_proto  = w_any & ~w_contig;
   assign w_under  = w_any & w_contig & (OccW'(w_k) > w_occ);
   assign w_cmp    = w_any & w_contig & ~w_under & (r_state == RUN);
   assign w_pop_cnt = w_cmp ? w_k : '0;

   cosim_multi_pop_fifo #(
      .Depth  (RefDepth),
      .PopW   (NumChannels),
      .item_t (commit_log_reg_item_t)
   ) u_ref_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_store),
      .push_item_i (w_push_item),
      .pop_cnt_i   (w_pop_cnt),
      .head_o      (w_head),
      .count_o     (w_occ)
   );

   // Lanes are contiguous when compared, so valid[i] selects exactly the first k lanes.
   always_comb begin
      w_nmatch = '0;
      w_nmis   = '0;
      w_found  = 1'b0;
      w_fkey   = '0;
      w_fexp   = '0;
      w_fgot   = '0;
      for (int i = 0; i < NumChannels; i++) begin
         if (dut_valid_i[i]) begin
            if ((KeyW'(w_head[i].key) == dut_key_i[i*KeyW +: KeyW]) &&
                (ValW'(w_head[i].value) == dut_value_i[i*ValW +: ValW])) begin
               w_nmatch = w_nmatch + KW'(1);
            end else begin
               w_nmis = w_nmis + KW'(1);
               if (!w_found) begin
                  w_found = 1'b1;
                  w_fkey  = KeyW'(w_head[i].key);
                  w_fexp  = ValW'(w_head[i].value);
                  w_fgot  = dut_value_i[i*ValW +: ValW];
               end
            end
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN: begin
            if (w_cmp && (w_nmis != '0) && cfg_halt_on_mismatch_i) begin
               w_state_next = HALT;
            end
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_match     <= 1'b0;
         r_mismatch  <= 1'b0;
         r_mm_vld    <= 1'b0;
         r_mm_key    <= '0;
         r_mm_exp    <= '0;
         r_mm_got    <= '0;
         r_match_cnt <= '0;
         r_mis_cnt   <= '0;
         r_skip_cnt  <= '0;
         r_underflow <= 1'b0;
         r_proto     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_match    <= w_cmp & (w_nmis == '0);
         r_mismatch <= w_cmp & (w_nmis != '0);
         if (w_cmp) begin
            r_match_cnt <= sat_add(r_match_cnt, w_nmatch);
            r_mis_cnt   <= sat_add(r_mis_cnt, w_nmis);
         end
         if (w_skip) begin
            r_skip_cnt <= sat_add(r_skip_cnt, KW'(1));
         end
         if (w_cmp && w_found && !r_mm_vld) begin
            r_mm_vld <= 1'b1;
            r_mm_key <= w_fkey;
            r_mm_exp <= w_fexp;
            r_mm_got <= w_fgot;
         end
         if (w_under) begin
            r_underflow <= 1'b1;
         end
         if (w_proto) begin
            r_proto <= 1'b1;
         end
      end
   end

   assign match_o          = r_match;
   assign mismatch_o       = r_mismatch;
   assign mm_key_o         = r_mm_key;
   assign mm_exp_o         = r_mm_exp;
   assign mm_got_o         = r_mm_got;
   assign match_count_o    = r_match_cnt;
   assign mismatch_count_o = r_mis_cnt;
   assign skip_count_o     = r_skip_cnt;
   assign occupancy_o      = w_occ;
   assign underflow_o      = r_underflow;
   assign protocol_err_o   = r_proto;
   assign halted_o         = (r_state == HALT);

endmodule

// File: tb/tb_cosim_commit_checker.sv
// Directed bench for cosim_commit_checker: hand-computed expectations for match, mismatch, halt, skip, error and wrap cases.
module tb_cosim_commit_checker;

   localparam int NCH = 2;
   localparam int DEP = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_skip = 1'b0;
   logic           cfg_halt = 1'b0;
   logic           ref_valid = 1'b0;
   logic           ref_ready;
   logic [63:0]    ref_key = '0;
   logic [127:0]   ref_value = '0;
   logic [1:0]     dut_valid = '0;
   logic [127:0]   dut_key = '0;
   logic [255:0]   dut_value = '0;
   logic           match_o, mismatch_o;
   logic [63:0]    mm_key;
   logic [127:0]   mm_exp, mm_got;
   logic [31:0]    match_cnt, mis_cnt, skip_cnt;
   logic [4:0]     occ;
   logic           underflow, proto_err, halted;

   int n_asserts = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cosim_commit_checker #(
      .NumChannels (NCH),
      .RefDepth    (DEP),
      .KeyW        (64),
      .ValW        (128),
      .CntW        (32)
   ) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .cfg_skip_csr_i         (cfg_skip),
      .cfg_halt_on_mismatch_i (cfg_halt),
      .ref_valid_i            (ref_valid),
      .ref_ready_o            (ref_ready),
      .ref_key_i              (ref_key),
      .ref_value_i            (ref_value),
      .dut_valid_i            (dut_valid),
      .dut_key_i              (dut_key),
      .dut_value_i            (dut_value),
      .match_o                (match_o),
      .mismatch_o             (mismatch_o),
      .mm_key_o               (mm_key),
      .mm_exp_o               (mm_exp),
      .mm_got_o               (mm_got),
      .match_count_o          (match_cnt),
      .mismatch_count_o       (mis_cnt),
      .skip_count_o           (skip_cnt),
      .occupancy_o            (occ),
      .underflow_o            (underflow),
      .protocol_err_o         (proto_err),
      .halted_o               (halted)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] k, input logic [127:0] v);
      ref_valid = 1'b1;
      ref_key   = k;
      ref_value = v;
      tick();
      ref_valid = 1'b0;
   endtask

   task automatic commit(input logic [1:0] vld, input logic [63:0] k0, input logic [127:0] v0,
                         input logic [63:0] k1, input logic [127:0] v1);
      dut_valid = vld;
      dut_key   = {k1, k0};
      dut_value = {v1, v0};
      tick();
      dut_valid = '0;
   endtask

   initial begin
      int exp_occ;
      int p;
      int q;
      logic exp_push;

      // Reset state
      tick();
      tick();
      check_eq("rst_ready", ref_ready, 0);
      check_eq("rst_occ", occ, 0);
      check_eq("rst_match", match_o, 0);
      check_eq("rst_mcnt", match_cnt, 0);
      check_eq("rst_halted", halted, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_ready", ref_ready, 1);

      // Two 2-lane matching commits
      push(64'h50, 128'h11);
      push(64'h50, 128'h22);
      push(64'h50, 128'h33);
      push(64'h50, 128'h44);
      check_eq("fill4_occ", occ, 4);
      commit(2'b11, 64'h50, 128'h11, 64'h50, 128'h22);
      check_eq("c1_match", match_o, 1);
      check_eq("c1_mismatch", mismatch_o, 0);
      check_eq("c1_occ", occ, 2);
      check_eq("c1_mcnt", match_cnt, 2);
      commit(2'b11, 64'h50, 128'h33, 64'h50, 128'h44);
      check_eq("c2_match", match_o, 1);
      check_eq("c2_occ", occ, 0);
      check_eq("c2_mcnt", match_cnt, 4);
      tick();
      check_eq("idle_match", match_o, 0);

      // Single-lane value mismatch
      push(64'h30, 128'hAA);
      commit(2'b01, 64'h30, 128'hAB, 64'h0, 128'h0);
      check_eq("mm_pulse", mismatch_o, 1);
      check_eq("mm_nomatch", match_o, 0);
      check_eq("mm_key", mm_key, 128'h30);
      check_eq("mm_exp", mm_exp, 128'hAA);
      check_eq("mm_got", mm_got, 128'hAB);
      check_eq("mm_cnt", mis_cnt, 1);
      check_eq("mm_not_halted", halted, 0);

      // Halt on mismatch freezes comparison
      cfg_halt = 1'b1;
      push(64'h60, 128'h01);
      push(64'h61, 128'h02);
      push(64'h62, 128'h03);
      commit(2'b01, 64'h60, 128'h99, 64'h0, 128'h0);
      check_eq("halt_mm_pulse", mismatch_o, 1);
      check_eq("halt_set", halted, 1);
      check_eq("halt_mmcnt", mis_cnt, 2);
      check_eq("halt_occ", occ, 2);
      check_eq("halt_mm_sticky", mm_exp, 128'hAA);
      commit(2'b11, 64'h61, 128'h02, 64'h62, 128'h03);
      check_eq("halted_no_match", match_o, 0);
      check_eq("halted_no_mm", mismatch_o, 0);
      check_eq("halted_occ", occ, 2);
      check_eq("halted_mcnt", match_cnt, 4);
      check_eq("halted_mmcnt", mis_cnt, 2);
      push(64'h63, 128'h04);
      check_eq("halted_push_occ", occ, 3);
      check_eq("halted_stays", halted, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cfg_halt = 1'b0;
      check_eq("halt_cleared", halted, 0);
      check_eq("halt_rst_occ", occ, 0);

      // CSR skip at push
      cfg_skip = 1'b1;
      push(64'h3004, 128'h5);
      push(64'h10, 128'h7);
      check_eq("skip_cnt", skip_cnt, 1);
      check_eq("skip_occ", occ, 1);
      cfg_skip = 1'b0;
      commit(2'b01, 64'h10, 128'h7, 64'h0, 128'h0);
      check_eq("skip_match", match_o, 1);
      check_eq("skip_mcnt", match_cnt, 1);

      // Underflow, then protocol error
      push(64'h20, 128'h8);
      commit(2'b11, 64'h20, 128'h8, 64'h0, 128'h0);
      check_eq("uf_flag", underflow, 1);
      check_eq("uf_no_match", match_o, 0);
      check_eq("uf_no_mm", mismatch_o, 0);
      check_eq("uf_occ", occ, 1);
      check_eq("uf_no_proto", proto_err, 0);
      commit(2'b10, 64'h0, 128'h0, 64'h20, 128'h8);
      check_eq("proto_flag", proto_err, 1);
      check_eq("proto_occ", occ, 1);
      check_eq("proto_no_match", match_o, 0);
      commit(2'b01, 64'h20, 128'h8, 64'h0, 128'h0);
      check_eq("drain_match", match_o, 1);
      check_eq("drain_occ", occ, 0);

      // Fill to full, then pop across the pointer wrap while pushing
      for (int i = 0; i < DEP; i++) begin
         push(64'h100 + 64'(i), 128'h1000 + 128'(i));
      end
      check_eq("full_occ", occ, 16);
      check_eq("full_ready", ref_ready, 0);
      exp_occ = 16;
      p = 0;
      q = 16;
      for (int c = 0; c < 10; c++) begin
         exp_push  = (exp_occ < DEP);
         ref_valid = 1'b1;
         ref_key   = 64'h100 + 64'(q);
         ref_value = 128'h1000 + 128'(q);
         dut_valid = (c == 0) ? 2'b01 : 2'b11;
         dut_key   = {64'h100 + 64'(p + 1), 64'h100 + 64'(p)};
         dut_value = {128'h1000 + 128'(p + 1), 128'h1000 + 128'(p)};
         tick();
         exp_occ = exp_occ + (exp_push ? 1 : 0) - ((c == 0) ? 1 : 2);
         if (exp_push) q++;
         p = p + ((c == 0) ? 1 : 2);
         check_eq($sformatf("wrap%0d_match", c), match_o, 1);
         check_eq($sformatf("wrap%0d_occ", c), occ, 128'(exp_occ));
         check_eq($sformatf("wrap%0d_ready", c), ref_ready, (exp_occ < DEP) ? 1 : 0);
      end
      check_eq("wrap_mcnt", match_cnt, 21);
      check_eq("wrap_mmcnt", mis_cnt, 0);

      // Reset mid-stream discards pending compare and entries
      dut_key   = {64'h100 + 64'(p + 1), 64'h100 + 64'(p)};
      dut_value = {128'h1000 + 128'(p + 1), 128'h1000 + 128'(p)};
      dut_valid = 2'b11;
      rst = 1'b1;
      tick();
      check_eq("mrst_occ", occ, 0);
      check_eq("mrst_match", match_o, 0);
      check_eq("mrst_mcnt", match_cnt, 0);
      check_eq("mrst_ready_low", ref_ready, 0);
      rst = 1'b0;
      ref_valid = 1'b0;
      dut_valid = '0;
      #1;
      check_eq("mrst_ready_high", ref_ready, 1);
      check_eq("mrst_uf", underflow, 0);
      check_eq("mrst_proto", proto_err, 0);
      check_eq("mrst_skip", skip_cnt, 0);
      tick();
      check_eq("mrst_no_pulse", match_o, 0);
      check_eq("mrst_occ2", occ, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
